// File: rtl/cpu_control_pkg.sv
// rtl/cpu_control_pkg.sv - RV32I base opcode constants and control bundle type
package cpu_control_pkg;

    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic branch;
        logic wb;
        logic jal;
        logic reg_write;
        logic reg_wirte_mux;
        logic mem_write;
        logic alu_input_mux;
        logic store;
        logic i_type;
        logic s_type;
        logic b_type;
        logic u_type;
        logic j_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cpu_control_decode.sv
// rtl/cpu_control_decode.sv - combinational opcode to control bundle table
module cpu_control_decode
    import cpu_control_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        unique case (opcode)
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_input_mux = 1'b1;
                ctrl.i_type        = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wb            = 1'b1;
                ctrl.alu_input_mux = 1'b1;
                ctrl.i_type        = 1'b1;
            end
            OPC_STORE: begin
                ctrl.mem_write     = 1'b1;
                ctrl.store         = 1'b1;
                ctrl.alu_input_mux = 1'b1;
                ctrl.s_type        = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.b_type = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl.reg_write     = 1'b1;
                ctrl.alu_input_mux = 1'b1;
                ctrl.u_type        = 1'b1;
            end
            OPC_JAL: begin
                ctrl.jal           = 1'b1;
                ctrl.reg_write     = 1'b1;
                ctrl.reg_wirte_mux = 1'b1;
                ctrl.j_type        = 1'b1;
            end
            OPC_JALR: begin
                ctrl.jal           = 1'b1;
                ctrl.reg_write     = 1'b1;
                ctrl.reg_wirte_mux = 1'b1;
                ctrl.alu_input_mux = 1'b1;
                ctrl.i_type        = 1'b1;
            end
            // MISC-MEM, SYSTEM and every unrecognised encoding decode as NOP
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - registered RV32I main decoder with synchronous clear
module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                branch,
    output logic                WB,
    output logic                jal,
    output logic                reg_write,
    output logic                reg_wirte_mux,
    output logic                mem_write,
    output logic                alu_input_mux,
    output logic                store,
    output logic                I_type,
    output logic                S_type,
    output logic                B_type,
    output logic                U_type,
    output logic                J_type
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    cpu_control_decode u_decode (
        .opcode (opcode),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign branch        = ctrl_q.branch;
    assign WB            = ctrl_q.wb;
    assign jal           = ctrl_q.jal;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_wirte_mux = ctrl_q.reg_wirte_mux;
    assign mem_write     = ctrl_q.mem_write;
    assign alu_input_mux = ctrl_q.alu_input_mux;
    assign store         = ctrl_q.store;
    assign I_type        = ctrl_q.i_type;
    assign S_type        = ctrl_q.s_type;
    assign B_type        = ctrl_q.b_type;
    assign U_type        = ctrl_q.u_type;
    assign J_type        = ctrl_q.j_type;

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - directed vector bench for cpu_control
module tb_cpu_control;

    localparam logic [12:0] E_BRANCH = 13'h1000;
    localparam logic [12:0] E_WB     = 13'h0800;
    localparam logic [12:0] E_JAL    = 13'h0400;
    localparam logic [12:0] E_RW     = 13'h0200;
    localparam logic [12:0] E_RWMUX  = 13'h0100;
    localparam logic [12:0] E_MEMW   = 13'h0080;
    localparam logic [12:0] E_ALUM   = 13'h0040;
    localparam logic [12:0] E_STORE  = 13'h0020;
    localparam logic [12:0] E_I      = 13'h0010;
    localparam logic [12:0] E_S      = 13'h0008;
    localparam logic [12:0] E_B      = 13'h0004;
    localparam logic [12:0] E_U      = 13'h0002;
    localparam logic [12:0] E_J      = 13'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic branch, WB, jal, reg_write, reg_wirte_mux, mem_write, alu_input_mux, store;
    logic I_type, S_type, B_type, U_type, J_type;
    logic [12:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .branch        (branch),
        .WB            (WB),
        .jal           (jal),
        .reg_write     (reg_write),
        .reg_wirte_mux (reg_wirte_mux),
        .mem_write     (mem_write),
        .alu_input_mux (alu_input_mux),
        .store         (store),
        .I_type        (I_type),
        .S_type        (S_type),
        .B_type        (B_type),
        .U_type        (U_type),
        .J_type        (J_type)
    );

    assign outs = {branch, WB, jal, reg_write, reg_wirte_mux, mem_write, alu_input_mux,
                   store, I_type, S_type, B_type, U_type, J_type};

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] model(input logic [6:0] op);
        case (op)
            7'b0110011: model = E_RW;
            7'b0010011: model = E_RW | E_ALUM | E_I;
            7'b0000011: model = E_RW | E_WB | E_ALUM | E_I;
            7'b0100011: model = E_MEMW | E_STORE | E_ALUM | E_S;
            7'b1100011: model = E_BRANCH | E_B;
            7'b0110111: model = E_RW | E_ALUM | E_U;
            7'b0010111: model = E_RW | E_ALUM | E_U;
            7'b1101111: model = E_JAL | E_RW | E_RWMUX | E_J;
            7'b1100111: model = E_JAL | E_RW | E_RWMUX | E_ALUM | E_I;
            default:    model = 13'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %013b expected %013b", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] op);
        rst    = r;
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{"zero",      7'b0000000, 13'h0000});
        vecs.push_back('{"all_ones",  7'b1111111, 13'h0000});
        vecs.push_back('{"load",      7'b0000011, E_RW | E_WB | E_ALUM | E_I});
        vecs.push_back('{"store",     7'b0100011, E_MEMW | E_STORE | E_ALUM | E_S});
        vecs.push_back('{"jal",       7'b1101111, E_JAL | E_RW | E_RWMUX | E_J});
        vecs.push_back('{"jalr",      7'b1100111, E_JAL | E_RW | E_RWMUX | E_ALUM | E_I});
        vecs.push_back('{"branch",    7'b1100011, E_BRANCH | E_B});
        vecs.push_back('{"lui",       7'b0110111, E_RW | E_ALUM | E_U});
        vecs.push_back('{"auipc",     7'b0010111, E_RW | E_ALUM | E_U});
        vecs.push_back('{"op",        7'b0110011, E_RW});
        vecs.push_back('{"op_imm",    7'b0010011, E_RW | E_ALUM | E_I});
        vecs.push_back('{"misc_mem",  7'b0001111, 13'h0000});
        vecs.push_back('{"system",    7'b1110011, 13'h0000});
        vecs.push_back('{"op_lo_bad", 7'b0110001, 13'h0000});
        vecs.push_back('{"jal_lo_bad",7'b1101110, 13'h0000});

        // reset holds everything clear even with a valid opcode present
        step(1'b1, 7'b0110011);
        check("reset_cycle1", outs, 13'h0000);
        step(1'b1, 7'b0110011);
        check("reset_cycle2", outs, 13'h0000);
        step(1'b0, 7'b0110011);
        check("after_reset_op", outs, E_RW);

        foreach (vecs[i]) begin
            step(1'b0, vecs[i].op);
            check(vecs[i].name, outs, vecs[i].exp);
        end

        // rst has priority mid-stream, and decode resumes on the next edge
        step(1'b0, 7'b1101111);
        check("pre_rst_jal", outs, E_JAL | E_RW | E_RWMUX | E_J);
        step(1'b1, 7'b0000011);
        check("rst_over_load", outs, 13'h0000);
        step(1'b0, 7'b0100011);
        check("post_rst_store", outs, E_MEMW | E_STORE | E_ALUM | E_S);

        // back-to-back sweep of every opcode plus invariants each cycle
        for (int k = 0; k < 128; k++) begin
            logic [6:0] op;
            logic [4:0] fmt;
            logic       inv_ok;
            op = 7'(k);
            step(1'b0, op);
            check($sformatf("sweep_%02h", op), outs, model(op));
            fmt = outs[4:0];
            inv_ok = ($countones(fmt) <= 1) && (mem_write == store) &&
                     (!WB || reg_write) && (!reg_wirte_mux || (jal && reg_write)) &&
                     !(branch && mem_write && reg_write);
            check($sformatf("invariant_%02h", op), {12'h000, inv_ok}, 13'h0001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Main instruction decoder of the RV32I core; sits between instruction fetch and the datapath.
- Decodes the 7-bit base opcode into registered datapath/control strobes and one-hot instruction-format flags.
- The immediate generator, register file, ALU mux, data memory and branch unit consume these outputs one cycle after the opcode is presented.

Parameters:
- OPCODE_W, 7, opcode width (fixed; not meant to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- opcode  input  7  instruction bits [6:0].
- branch  output  1  conditional branch instruction (B-type).
- WB  output  1  writeback data comes from data memory (loads).
- jal  output  1  jump instruction (JAL or JALR); PC redirect.
- reg_write  output  1  register file write enable.
- reg_wirte_mux  output  1  writeback select PC+4 (1) vs ALU/memory path (0).
- mem_write  output  1  data memory write strobe.
- alu_input_mux  output  1  ALU operand B = immediate (1) / rs2 (0).
- store  output  1  store instruction; rs2 drives store data.
- I_type, S_type, B_type, U_type, J_type  output  1 each  one-hot immediate-format flags.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered; decode of opcode sampled at rising edge N is visible after edge N; latency is 1 cycle, throughput 1 per cycle, no handshake.
- rst=1 at a rising edge: every output becomes 0 on that edge, regardless of opcode; rst has priority.
- Decode table (outputs not listed are 0):
  - 0110011 OP: reg_write.
  - 0010011 OP-IMM: reg_write, alu_input_mux, I_type.
  - 0000011 LOAD: reg_write, WB, alu_input_mux, I_type.
  - 0100011 STORE: mem_write, store, alu_input_mux, S_type.
  - 1100011 BRANCH: branch, B_type.
  - 0110111 LUI: reg_write, alu_input_mux, U_type.
  - 0010111 AUIPC: reg_write, alu_input_mux, U_type.
  - 1101111 JAL: jal, reg_write, reg_wirte_mux, J_type.
  - 1100111 JALR: jal, reg_write, reg_wirte_mux, alu_input_mux, I_type.
  - 0001111 MISC-MEM and 1110011 SYSTEM: all 0 (treated as NOP).
  - Any other value, including opcode=0 and opcode[1:0]!=2'b11: all 0.
- Invariants: at most one format flag high; mem_write==store; WB implies reg_write; reg_wirte_mux implies jal and reg_write; branch, mem_write and reg_write never all asserted together.
- Opcode changing every cycle: each output reflects only the immediately preceding sampled opcode; no state beyond the output registers.

Decomposition:
- Shared package: localparams for the nine opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR) plus OPC_MISC_MEM, OPC_SYSTEM.
- Optional control-bundle struct in the same package.
- One natural sub-module: cpu_control_decode, purely combinational opcode-to-bundle table.
- The top-level module adds the reset-clearing output register stage.

Test Plan:
- Reset: rst=1 with opcode=7'b0110011 for 2 cycles -> all 13 outputs 0; deassert rst -> next edge reg_write=1, everything else 0.
- Idle/illegal: opcode=0, then 7'b1111111 -> all outputs 0 after each edge.
- Memory path: opcode=7'b0000011 -> reg_write=WB=alu_input_mux=I_type=1; then 7'b0100011 -> mem_write=store=alu_input_mux=S_type=1, reg_write=0.
- Jumps: 7'b1101111 -> jal=reg_write=reg_wirte_mux=J_type=1, alu_input_mux=0; 7'b1100111 -> same plus alu_input_mux=1, I_type=1, J_type=0.
- Branch/U-type: 7'b1100011 -> branch=B_type=1 only; 7'b0110111 and 7'b0010111 -> reg_write=alu_input_mux=U_type=1.
- Back-to-back sweep: all 128 opcodes one per cycle -> each output matches the table one cycle later; one-hot format invariant holds every cycle.
